regfile_2r1w: RTL

- 32-entry general-purpose register file for the single-cycle CPU, directly downstream of the 5-bit write-register select mux.
- The select mux chooses between the rt and rd fields; its output drives wr_addr here.
- Provides two combinational read ports (rs, rt) for the datapath, one synchronous write port, and one debug read port for the board display.
- Keeps a write-event counter and the last-written register index for on-board debug.

---
 rtl/regfile_2r1w.sv | 109 ++++++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32 x DATA_W general-purpose register file for the single-cycle CPU.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset; clears registers, counter and last index
//   rs_addr      read port A address (instr[25:21])
//   rt_addr      read port B address (instr[20:16])
//   wr_addr      write address from the write-register select mux
//   wr_data      write data (ALU result or memory data)
//   reg_write    write enable from the control unit
//   rs_data      read port A data, combinational
//   rt_data      read port B data, combinational
//   dbg_addr     debug read address (board switches)
//   dbg_data     debug read data, combinational, never bypassed
//   wr_count     number of effective writes since reset, wraps modulo 2^CNT_W
//   last_wr_addr index of the most recent effective write
//
// Register 0 is hardwired to zero on every read port and is never written.
// BYPASS=1 makes rs/rt return the pending write data when their address matches.

module regfile_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter bit          BYPASS = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count,
  output logic [4:0]        last_wr_addr
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [4:0]        last_q, last_d;
  logic              wr_en;

  // Writes to r0 are dropped entirely; they neither count nor move last_wr_addr.
  // Gating with rst_n also suppresses bypass while reset is asserted.
  assign wr_en = rst_n & reg_write & (wr_addr != 5'd0);

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    last_d  = last_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
      count_d         = count_q + CNT_W'(1);
      last_d          = wr_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
      last_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    rs_data = '0;
    if (rs_addr != 5'd0) begin
      if (BYPASS && wr_en && (rs_addr == wr_addr)) begin
        rs_data = wr_data;
      end else begin
        rs_data = regs_q[rs_addr];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != 5'd0) begin
      if (BYPASS && wr_en && (rt_addr == wr_addr)) begin
        rt_data = wr_data;
      end else begin
        rt_data = regs_q[rt_addr];
      end
    end
  end

  // The debug port always shows committed state.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != 5'd0) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

  assign wr_count     = count_q;
  assign last_wr_addr = last_q;

endmodule
